// File: rtl/button_event_decoder.sv
// Button event decoder: turns debounced press/release pulses into
// single-click, double-click, long-press and auto-repeat events.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - synchronous active-high reset
//   pb_state     - debounced level, 1 while the button is down
//   pb_down      - one-clock pulse on a debounced press
//   pb_up        - one-clock pulse on a debounced release
//   short_press  - one-clock pulse for a single short click
//   double_click - one-clock pulse for two clicks inside the window
//   long_press   - one-clock pulse when the hold reaches LONG_CNT clocks
//   repeat_pulse - one-clock pulse every REPEAT_CNT clocks while held long
//                  (the name "repeat" is a reserved word)
//   busy         - high whenever the FSM is not idle
//
// Requires 2 <= LONG_CNT, DBL_CNT, REPEAT_CNT < 2**CW.
module button_event_decoder #(
  parameter int unsigned CW         = 24,
  parameter int unsigned LONG_CNT   = 12_000_000,
  parameter int unsigned DBL_CNT    = 4_000_000,
  parameter int unsigned REPEAT_CNT = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_state,
  input  logic pb_down,
  input  logic pb_up,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] DBL_LAST    = CW'(DBL_CNT - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CNT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          short_q, short_d;
  logic          double_q, double_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          busy_q, busy_d;

  // Simultaneous press and release cancel each other; presses are only
  // honoured once the button has been seen released since reset.
  logic dn, up;
  assign dn = pb_down & ~pb_up & armed_q;
  assign up = pb_up & ~pb_down;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q | ~pb_state;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dn) state_d = PRESS1;
      end
      PRESS1: begin
        // Release wins over a timeout on the same clock.
        if (up) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT2: begin
        // Second press wins over a timeout on the same clock.
        if (dn) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == DBL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS2: begin
        cnt_d = '0;
        if (up) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      LONG: begin
        if (up) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;

endmodule
